dmem_port_arbiter: RTL

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a burst DMA/loader port.
- CPU has priority. A starvation counter guarantees the DMA port one beat after at most MAX_WAIT consecutive CPU-won cycles.
- The block sequences DMA bursts (address generation, beat counting, completion) and drives the memory's write-enable, address and write-data.
- It sits between the MEM stage / DMA engine and the data memory. The memory has a synchronous write and a combinational read.

---
 rtl/dmem_port_arbiter_pkg.sv | 13 +
 rtl/dmem_dma_addr_gen.sv | 43 ++++
 rtl/dmem_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
// FSM encoding and the byte/word shift used by burst addressing.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/dmem_dma_addr_gen.sv
// DMA burst address generator: latches base/len at start,
// counts beats and flags the final beat of the burst.
module dmem_dma_addr_gen
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LEN_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     adv,
  input  logic [ADDRESS_WIDTH-1:0] base_in,
  input  logic [LEN_W-1:0]         len_in,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     last_beat
);

  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      base_q   <= base_in;
      len_q    <= len_in;
      beat_cnt <= '0;
    end else if (adv) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // Word-stride address; wraps naturally at the top of the space.
  assign addr = base_q
              + (ADDRESS_WIDTH'(beat_cnt) << WORD_SHIFT);

  assign last_beat = (beat_cnt == len_q - LEN_W'(1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU-priority sharing with a DMA
// burst engine, bounded DMA starvation via a wait counter.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_W         = 8,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     dma_start,
  input  logic                     dma_we,
  input  logic [ADDRESS_WIDTH-1:0] dma_base,
  input  logic [LEN_W-1:0]         dma_len,
  input  logic [DATA_WIDTH-1:0]    dma_wdata,
  output logic                     dma_wready,
  output logic [DATA_WIDTH-1:0]    dma_rdata,
  output logic                     dma_rvalid,
  output logic                     dma_busy,
  output logic                     dma_done,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  state_t state_q, state_d;
  logic [3:0] wait_cnt;
  logic       we_q;
  logic       load, adv, wait_inc;
  logic       gnt, last_beat;
  logic [ADDRESS_WIDTH-1:0] beat_addr;

  dmem_dma_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .LEN_W        (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .adv      (adv),
    .base_in  (dma_base),
    .len_in   (dma_len),
    .addr     (beat_addr),
    .last_beat(last_beat)
  );

  assign gnt = !cpu_req | (wait_cnt == 4'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)
        we_q <= dma_we;
      // wait_cnt never passes MAX_WAIT: reaching it forces a grant.
      if (load || adv)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = cpu_req & cpu_we;
    cpu_stall  = 1'b0;
    dma_wready = 1'b0;
    dma_rvalid = 1'b0;
    dma_done   = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    wait_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_start) begin
          load    = 1'b1;
          state_d = (dma_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (gnt) begin
          mem_addr   = beat_addr;
          mem_wdata  = dma_wdata;
          mem_we     = we_q;
          cpu_stall  = cpu_req;
          dma_wready = we_q;
          dma_rvalid = !we_q;
          adv        = 1'b1;
          if (last_beat)
            state_d = DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      DONE: begin
        dma_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_busy  = (state_q != IDLE);
  assign dma_rdata = mem_rdata;
  assign cpu_rdata = mem_rdata;

endmodule
